// File: rtl/stack_upstream_receiver_pkg.sv
// stack_upstream_receiver_pkg
// Shared definitions for the manager-side upstream stack receiver: default
// bus widths, buffer sizing, cntl field encodings and framing FSM states.
// No ports (package).
package stack_upstream_receiver_pkg;

  localparam int STU_DATA_W   = 32;  // upstream payload width
  localparam int STU_OOB_W    = 8;   // out-of-band payload width
  localparam int STU_TYPE_W   = 2;   // control/data, vector/scalar
  localparam int STU_CNTL_W   = 2;   // framing field width
  localparam int STU_RX_DEPTH = 8;   // receive buffer entries (power of 2)
  localparam int STU_RX_SKID  = 3;   // entries reserved for in-flight words

  // Packet framing marker carried on the cntl field.
  typedef enum logic [1:0] {
    CNTL_MOM     = 2'b00,
    CNTL_SOM     = 2'b01,
    CNTL_EOM     = 2'b10,
    CNTL_SOM_EOM = 2'b11
  } cntl_e;

  // Framing FSM: between packets, or inside a multi-word packet.
  typedef enum logic {
    STU_RX_IDLE   = 1'b0,
    STU_RX_IN_PKT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/stack_upstream_receiver_if.sv
// stack_upstream_receiver_if
// Bundles the PE-to-receiver upstream word stream, the receiver-to-manager
// stream and the status outputs.
//   slave  : the receiver (consumes pe__stu__*, mgr__stu__ready; drives the rest)
//   master : the environment driving the PE side and the manager ready
interface stack_upstream_receiver_if
  import stack_upstream_receiver_pkg::*;
#(
  parameter int DATA_W = STU_DATA_W,
  parameter int OOB_W  = STU_OOB_W,
  parameter int TYPE_W = STU_TYPE_W,
  parameter int CNTL_W = STU_CNTL_W
) ();

  // PE -> receiver
  logic              pe__stu__valid;
  logic [CNTL_W-1:0] pe__stu__cntl;
  logic [TYPE_W-1:0] pe__stu__type;
  logic [DATA_W-1:0] pe__stu__data;
  logic [OOB_W-1:0]  pe__stu__oob_data;
  logic              stu__pe__ready;

  // receiver -> manager
  logic              stu__mgr__valid;
  logic [CNTL_W-1:0] stu__mgr__cntl;
  logic [TYPE_W-1:0] stu__mgr__type;
  logic [DATA_W-1:0] stu__mgr__data;
  logic [OOB_W-1:0]  stu__mgr__oob_data;
  logic              mgr__stu__ready;

  // status
  logic              stu__mgr__frame_err;
  logic              stu__mgr__ovfl_err;
  logic [15:0]       stu__mgr__pkt_count;

  modport slave (
    input  pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
           pe__stu__oob_data, mgr__stu__ready,
    output stu__pe__ready, stu__mgr__valid, stu__mgr__cntl, stu__mgr__type,
           stu__mgr__data, stu__mgr__oob_data, stu__mgr__frame_err,
           stu__mgr__ovfl_err, stu__mgr__pkt_count
  );

  modport master (
    output pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
           pe__stu__oob_data, mgr__stu__ready,
    input  stu__pe__ready, stu__mgr__valid, stu__mgr__cntl, stu__mgr__type,
           stu__mgr__data, stu__mgr__oob_data, stu__mgr__frame_err,
           stu__mgr__ovfl_err, stu__mgr__pkt_count
  );

endinterface

// File: rtl/stack_upstream_receiver_fifo.sv
// stu_rx_fifo
// Generic synchronous FIFO holding packed {cntl, type, data, oob} words.
// The caller guarantees push only when there is room (or a pop in the same
// cycle) and pop only when count != 0.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_word at the tail
//   push_word  : word to write
//   pop        : retire the head entry
//   count      : occupied entries (0..DEPTH)
//   head       : head entry, zero while empty
module stu_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_word,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count define validity, and
  // the head is forced to zero while empty so outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Push at full with a pop writes the slot being retired this same edge;
  // the head is read before the edge, so ordering is preserved.
  assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/stack_upstream_receiver.sv
// stack_upstream_receiver
// Manager-side terminus of the PE upstream stack bus. Captures every valid
// word (ready does not qualify capture), checks SOM/MOM/EOM framing, buffers
// legal words with a skid reserve for words still in flight after ready
// falls, and presents the buffer head to the stack manager.
//   clk           : clock, rising edge
//   reset_poweron : asynchronous active-high reset
//   bus (slave)   : pe__stu__* in, stu__pe__ready out, stu__mgr__* out,
//                   mgr__stu__ready in, frame/overflow errors, packet count
module stack_upstream_receiver
  import stack_upstream_receiver_pkg::*;
#(
  parameter int DATA_W = STU_DATA_W,
  parameter int OOB_W  = STU_OOB_W,
  parameter int TYPE_W = STU_TYPE_W,
  parameter int CNTL_W = STU_CNTL_W,
  parameter int DEPTH  = STU_RX_DEPTH,
  parameter int SKID   = STU_RX_SKID
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  stack_upstream_receiver_if.slave  bus
);

  localparam int WORD_W = CNTL_W + TYPE_W + DATA_W + OOB_W;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LVL = CW'(DEPTH - SKID);

  rx_state_e     state_q, state_d;
  cntl_e         cntl_in;
  logic          legal, frame_bad, pkt_done;
  logic          push, pop;
  logic [CW-1:0] count, count_next;
  logic          ready_q, frame_err_q, ovfl_err_q;
  logic [15:0]   pkt_count_q;
  logic [WORD_W-1:0] push_word, head;

  assign cntl_in = cntl_e'(bus.pe__stu__cntl);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    legal     = 1'b0;
    frame_bad = 1'b0;
    pkt_done  = 1'b0;
    if (bus.pe__stu__valid) begin
      case (state_q)
        STU_RX_IDLE: begin
          case (cntl_in)
            CNTL_SOM:     begin legal = 1'b1; state_d = STU_RX_IN_PKT; end
            CNTL_SOM_EOM: begin legal = 1'b1; pkt_done = 1'b1; end
            default:      frame_bad = 1'b1;
          endcase
        end
        STU_RX_IN_PKT: begin
          case (cntl_in)
            CNTL_MOM: legal = 1'b1;
            CNTL_EOM: begin legal = 1'b1; pkt_done = 1'b1; state_d = STU_RX_IDLE; end
            default:  frame_bad = 1'b1;
          endcase
        end
        default: state_d = STU_RX_IDLE;
      endcase
    end
  end

  // A pop frees a slot this edge, so a legal word still fits at full.
  assign pop        = (count != '0) && bus.mgr__stu__ready;
  assign push       = legal && ((count < FULL_LVL) || pop);
  assign count_next = count + CW'(push) - CW'(pop);
  assign push_word  = {bus.pe__stu__cntl, bus.pe__stu__type,
                       bus.pe__stu__data, bus.pe__stu__oob_data};

  // Framing state and pkt_count advance on every legal word, even one dropped
  // for overflow, so the framing check stays aligned with the PE's stream.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q     <= STU_RX_IDLE;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ovfl_err_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (count_next < READY_LVL);
      frame_err_q <= frame_err_q | frame_bad;
      ovfl_err_q  <= ovfl_err_q | (legal && !push);
      pkt_count_q <= pkt_count_q + 16'(pkt_done);
    end
  end

  stu_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset_poweron),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.stu__pe__ready      = ready_q;
  assign bus.stu__mgr__valid     = (count != '0);
  assign {bus.stu__mgr__cntl, bus.stu__mgr__type,
          bus.stu__mgr__data, bus.stu__mgr__oob_data} = head;
  assign bus.stu__mgr__frame_err = frame_err_q;
  assign bus.stu__mgr__ovfl_err  = ovfl_err_q;
  assign bus.stu__mgr__pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stack_upstream_receiver.sv
// tb_stack_upstream_receiver
// Directed bench for stack_upstream_receiver: reset values, single-word
// packets, back-pressure with a two-stage registered PE, full-with-pop,
// overflow, framing violations and reset in the middle of a packet.
module tb_stack_upstream_receiver;
  import stack_upstream_receiver_pkg::*;

  logic clk;
  logic reset_poweron;
  int   checks;
  int   errors;
  int   sent;
  int   popped;
  logic rdy_prev;
  logic drive;

  stack_upstream_receiver_if bus ();

  stack_upstream_receiver dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input cntl_e c, input logic [31:0] d);
    bus.pe__stu__valid    = 1'b1;
    bus.pe__stu__cntl     = c;
    bus.pe__stu__type     = 2'b01;
    bus.pe__stu__data     = d;
    bus.pe__stu__oob_data = d[7:0];
  endtask

  task automatic idle();
    bus.pe__stu__valid = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_poweron         = 1'b1;
    bus.pe__stu__valid    = 1'b0;
    bus.pe__stu__cntl     = '0;
    bus.pe__stu__type     = '0;
    bus.pe__stu__data     = '0;
    bus.pe__stu__oob_data = '0;
    bus.mgr__stu__ready   = 1'b0;
    #1;

    // Reset values
    check("rst_ready", bus.stu__pe__ready, 0);
    check("rst_valid", bus.stu__mgr__valid, 0);
    check("rst_data", bus.stu__mgr__data, 0);
    check("rst_pkt_count", bus.stu__mgr__pkt_count, 0);
    check("rst_frame_err", bus.stu__mgr__frame_err, 0);
    check("rst_ovfl_err", bus.stu__mgr__ovfl_err, 0);
    @(negedge clk);
    reset_poweron = 1'b0;
    check("ready_before_edge", bus.stu__pe__ready, 0);
    tick();
    check("ready_first_edge", bus.stu__pe__ready, 1);

    // Ten single-word packets, manager always ready
    bus.mgr__stu__ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(CNTL_SOM_EOM, 32'h10 + i);
      tick();
      check("sw_valid", bus.stu__mgr__valid, 1);
      check("sw_data", bus.stu__mgr__data, 32'h10 + i);
      check("sw_cntl", bus.stu__mgr__cntl, CNTL_SOM_EOM);
    end
    check("sw_type", bus.stu__mgr__type, 2'b01);
    check("sw_oob", bus.stu__mgr__oob_data, 8'h19);
    idle();
    tick();
    check("sw_drained", bus.stu__mgr__valid, 0);
    check("sw_pkt_count", bus.stu__mgr__pkt_count, 10);
    check("sw_frame_err", bus.stu__mgr__frame_err, 0);
    check("sw_ovfl_err", bus.stu__mgr__ovfl_err, 0);

    // Back-pressure: PE sees ready one cycle late (its own register stage)
    bus.mgr__stu__ready = 1'b0;
    sent     = 0;
    popped   = 0;
    rdy_prev = bus.stu__pe__ready;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 15) bus.mgr__stu__ready = 1'b1;
      if (bus.stu__mgr__valid && bus.mgr__stu__ready) begin
        check("skid_order", bus.stu__mgr__data, 32'h100 + popped);
        popped++;
      end
      drive    = (sent < 8) && rdy_prev;
      rdy_prev = bus.stu__pe__ready;
      if (drive)
        send((sent == 0) ? CNTL_SOM : ((sent == 7) ? CNTL_EOM : CNTL_MOM),
             32'h100 + sent);
      else
        idle();
      tick();
      if (drive) begin
        sent++;
        if (sent == 4) check("skid_ready_after_4", bus.stu__pe__ready, 1);
        if (sent == 5) check("skid_ready_after_5", bus.stu__pe__ready, 0);
      end
    end
    check("skid_popped", popped, 8);
    check("skid_ovfl_err", bus.stu__mgr__ovfl_err, 0);
    check("skid_pkt_count", bus.stu__mgr__pkt_count, 11);
    check("skid_empty", bus.stu__mgr__valid, 0);

    // Fill to full ignoring ready
    bus.mgr__stu__ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? CNTL_SOM : CNTL_MOM, 32'h200 + i);
      tick();
    end
    check("full_ovfl_err", bus.stu__mgr__ovfl_err, 0);
    check("full_ready", bus.stu__pe__ready, 0);
    check("full_head", bus.stu__mgr__data, 32'h200);

    // Push at full with a simultaneous pop
    bus.mgr__stu__ready = 1'b1;
    send(CNTL_EOM, 32'h2FF);
    tick();
    bus.mgr__stu__ready = 1'b0;
    check("fullpop_ovfl_err", bus.stu__mgr__ovfl_err, 0);
    check("fullpop_head", bus.stu__mgr__data, 32'h201);
    check("fullpop_pkt_count", bus.stu__mgr__pkt_count, 12);

    // Overflow: legal word at full with no pop is dropped
    send(CNTL_SOM_EOM, 32'h3FF);
    tick();
    idle();
    check("ovfl_err", bus.stu__mgr__ovfl_err, 1);
    check("ovfl_pkt_count", bus.stu__mgr__pkt_count, 13);
    check("ovfl_frame_err", bus.stu__mgr__frame_err, 0);
    check("ovfl_head", bus.stu__mgr__data, 32'h201);

    // Drain: 0x201..0x207 then 0x2FF, nothing from the dropped word
    bus.mgr__stu__ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", bus.stu__mgr__valid, 1);
      check("drain_data", bus.stu__mgr__data, (i < 7) ? 32'h201 + i : 32'h2FF);
      tick();
    end
    check("drain_empty", bus.stu__mgr__valid, 0);
    check("drain_ready", bus.stu__pe__ready, 1);

    // Framing violations
    send(CNTL_EOM, 32'h400);
    tick();
    check("frm_eom_idle_err", bus.stu__mgr__frame_err, 1);
    check("frm_eom_dropped", bus.stu__mgr__valid, 0);
    send(CNTL_SOM, 32'h401);
    tick();
    check("frm_som_data", bus.stu__mgr__data, 32'h401);
    send(CNTL_SOM, 32'h402);
    tick();
    check("frm_som2_dropped", bus.stu__mgr__valid, 0);
    send(CNTL_EOM, 32'h403);
    tick();
    check("frm_eom_data", bus.stu__mgr__data, 32'h403);
    check("frm_pkt_count", bus.stu__mgr__pkt_count, 14);
    idle();
    tick();

    // Reset in the middle of a packet
    bus.mgr__stu__ready = 1'b0;
    send(CNTL_SOM, 32'h500);
    tick();
    send(CNTL_MOM, 32'h501);
    tick();
    check("mid_valid_before_rst", bus.stu__mgr__valid, 1);
    send(CNTL_MOM, 32'h502);
    #2;
    reset_poweron = 1'b1;
    #1;
    check("mid_rst_valid", bus.stu__mgr__valid, 0);
    check("mid_rst_data", bus.stu__mgr__data, 0);
    check("mid_rst_ready", bus.stu__pe__ready, 0);
    check("mid_rst_frame_err", bus.stu__mgr__frame_err, 0);
    check("mid_rst_pkt_count", bus.stu__mgr__pkt_count, 0);
    @(negedge clk);
    reset_poweron = 1'b0;
    tick();
    idle();
    check("mid_mom_frame_err", bus.stu__mgr__frame_err, 1);
    check("mid_ready_first_edge", bus.stu__pe__ready, 1);
    check("mid_mom_dropped", bus.stu__mgr__valid, 0);
    check("mid_ovfl_err", bus.stu__mgr__ovfl_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_upstream_receiver.md
# stack_upstream_receiver

Manager-side terminus of the PE upstream stack bus. It accepts the registered upstream word stream a PE drives on `pe__stu__*`, and absorbs the in-flight words that arrive after back-pressure because the PE path registers both `valid` and `ready`. It also checks SOM/MOM/EOM packet framing and presents a clean, flow-controlled stream to the stack manager.

## Interface
- `DATA_W`, default `` `STACK_UP_INTF_DATA_WIDTH``: upstream data width.
- `OOB_W`, default `` `STACK_UP_INTF_OOB_DATA_WIDTH``: out-of-band data width.
- `TYPE_W`, default `` `STACK_UP_INTF_TYPE_WIDTH``: type field width.
- `CNTL_W`, default `` `COMMON_STD_INTF_CNTL_WIDTH``: cntl field width (2).
- `DEPTH`, default 8: buffer entries, power of 2.
- `SKID`, default 3: entries reserved for words in flight after `ready` falls.
- `clk` input 1: single clock, rising edge.
- `reset_poweron` input 1: asynchronous, active-high reset.
- `pe__stu__valid` input 1: word valid, qualified by nothing else; the PE may drive it while `ready` is low.
- `pe__stu__cntl` input CNTL_W: SOM, MOM, EOM or SOM_EOM.
- `pe__stu__type` input TYPE_W: control/data, vector/scalar; passed through.
- `pe__stu__data` input DATA_W: payload.
- `pe__stu__oob_data` input OOB_W: out-of-band payload.
- `stu__pe__ready` output 1: registered back-pressure to the PE.
- `stu__mgr__valid` output 1: output word valid.
- `stu__mgr__cntl` output CNTL_W: output cntl field.
- `stu__mgr__type` output TYPE_W: output type field.
- `stu__mgr__data` output DATA_W: output payload.
- `stu__mgr__oob_data` output OOB_W: output out-of-band payload.
- `mgr__stu__ready` input 1: manager accepts the word when this and `stu__mgr__valid` are both high.
- `stu__mgr__frame_err` output 1: sticky; set on a framing violation.
- `stu__mgr__ovfl_err` output 1: sticky; set on a word dropped because the buffer is full.
- `stu__mgr__pkt_count` output 16: count of completed packets, wraps.

## Operation
- **Capture.** A word is captured on every edge where `pe__stu__valid`=1. `ready` does not qualify capture; the skid region absorbs late words.
- **Framing FSM, state IDLE.**
  - SOM: push, go to IN_PKT.
  - SOM_EOM: push, stay IDLE, increment `pkt_count`.
  - MOM or EOM: drop the word, set `frame_err`.
- **Framing FSM, state IN_PKT.**
  - MOM: push.
  - EOM: push, go to IDLE, increment `pkt_count`.
  - SOM or SOM_EOM: drop the word, set `frame_err`, stay IN_PKT.
- **Push condition.** A word that is legal for framing is pushed when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- **Overflow.** Otherwise the word is dropped and `ovfl_err` is set. FSM state and `pkt_count` still advance as though the word had been accepted, so framing stays aligned.
- **Pop.** A pop occurs when `stu__mgr__valid && mgr__stu__ready`.
- **Output.** The output is the FIFO head. `stu__mgr__valid` equals `count != 0`, and the `stu__mgr__*` fields come from head storage, stable while valid and not ready.
- **Errors.** `frame_err` and `ovfl_err` clear only on reset.

## Timing
- **Reset values.** All outputs are 0: `ready`, `valid`, errors, `pkt_count`, data fields. The FSM is IDLE and `count`=0.
- **Ready after reset.** `stu__pe__ready` rises on the first edge after reset deasserts.
- **Latency.** A word captured at edge N appears on `stu__mgr__*` in the cycle after N. It can pop at edge N+1 at the earliest.
- **Ready.** At each edge, `stu__pe__ready` <= (`count_next` < DEPTH−SKID), i.e. `count_next` ≤ 4 at defaults.
- **Skid.** Because `ready` is registered here and again in the PE, up to SKID words may arrive after `ready` falls. With the PE obeying `ready`, no overflow can occur.
- **Simultaneous push and pop.** `count` is unchanged. Push at full with a pop in the same cycle succeeds.
- **Counter wrap.** `pkt_count` wraps from 0xFFFF to 0x0000.
- **Reset mid-packet.** Buffer contents are discarded and the FSM returns to IDLE. A following MOM or EOM from the PE is flagged as `frame_err`.

## Structure
- Shared include `stack_interface.vh` holds:
  - `STU_RX_DEPTH` and `STU_RX_SKID`;
  - FSM state encodings `STU_RX_IDLE` and `STU_RX_IN_PKT`.
- Cntl encodings `COMMON_STD_INTF_CNTL_SOM/MOM/EOM/SOM_EOM` come from `common.vh`.
- One sub-module, `stu_rx_fifo`:
  - generic synchronous FIFO with a packed {cntl, type, data, oob} word;
  - provides push, pop, count, head;
  - resets asynchronously.
- The framing FSM, error flags, ready register and packet counter live in the top module.

## Test plan
- **Single-word packets.** Send 10 consecutive SOM_EOM words with manager ready=1 → 10 words out, each 1 cycle after capture. `pkt_count`=10, no errors.
- **Back-pressure with skid.** Hold manager ready=0 and stream one 8-word SOM…EOM packet, with the PE obeying `ready` through 2 register stages. `ready` falls after the 5th word is captured, the buffer fills to ≤8, and `ovfl_err`=0. Releasing the manager drains all 8 words in order.
- **Overflow.** Hold manager ready=0, ignore `ready`, and drive 9 legal words → the 9th is dropped, `ovfl_err`=1, and the FIFO holds the first 8.
- **Framing violations.** Send EOM in IDLE → dropped, `frame_err`=1. Send SOM, then SOM → the second SOM is dropped and the state stays IN_PKT. A following EOM then completes the packet and `pkt_count` increments by 1.
- **Full with simultaneous pop.** At `count`=8 with manager ready=1 and a word arriving, `count` stays 8 and no error is raised.
- **Reset mid-packet.** Send SOM, MOM, then assert reset asynchronously → all outputs go to 0 immediately. After release, a MOM raises `frame_err` and `ready` returns to 1 on the first edge.
